pwm_multi_driver: RTL and testbench
===================================

# pwm_multi_driver

Multi-channel successor to the single-channel PWM driver: NUM_CH outputs share one period counter, each with its own duty, phase offset and output polarity. All settings are written through a small configuration port into shadow registers and committed together at a period boundary, so a multi-channel update never produces a glitched or partial period. Sits between the register/control layer and the pad drivers for motor, LED and fan control.

## Interface
- PWM_SIZE, 32: width of the counter, period, duty and phase values.
- NUM_CH, 4: number of PWM channels (1..32).
- CH_W, derived as max(1, $clog2(NUM_CH)): width of the channel-select field.
- clk  in  1  system clock; all state is on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- enable  in  1  1 = counter runs; 0 = counter held at 0 and outputs idle.
- cfg_we  in  1  write strobe for the shadow registers, one write per cycle.
- cfg_sel  in  2  target: 0 = duty[ch], 1 = phase[ch], 2 = period (cfg_ch ignored), 3 = polarity[ch] (cfg_data[0]).
- cfg_ch  in  CH_W  channel index; writes with cfg_ch >= NUM_CH are dropped.
- cfg_data  in  PWM_SIZE  write data.
- cfg_commit  in  1  request to copy all shadows to the active set at the next boundary.
- commit_pending  out  1  commit requested but not yet applied.
- period_start  out  1  one-cycle pulse aligned with the first output cycle of each period.
- pwm_out  out  NUM_CH  PWM outputs.

## Operation
- Reset values:
  - All shadow and active registers are 0.
  - cnt is 0.
  - commit_pending is 0.
  - period_start is 0.
  - pwm_out is 0.
- Counter:
  - When enable=1 and active period P >= 1, cnt counts 0..P-1 and wraps to 0.
  - When P = 0, cnt is held at 0 and all raw outputs are 0.
- Boundary:
  - A boundary is a clock edge where enable=1 and cnt = P-1.
  - Or any edge where the counter is idle (enable=0 or P=0).
- Commit:
  - A cfg_commit pulse sets commit_pending. Repeated pulses while pending have no effect.
  - At a boundary edge where (commit_pending | cfg_commit) is true: active set <= shadow set, cnt <= 0, and commit_pending <= 0.
  - A cfg_commit that coincides with a boundary applies at that same edge.
  - A cfg_we in the same cycle as a commit edge is excluded from that commit and stays in the shadow set.
- Channel position:
  - Phase adjustment: ph_i = (phase_i < P) ? phase_i : 0.
  - Position: pos_i = (cnt >= ph_i) ? cnt - ph_i : cnt + P - ph_i. Compute in PWM_SIZE+1 bits; the result is always < P.
- Raw output: raw_i = (pos_i < duty_i).
  - duty_i = 0 gives constant low.
  - duty_i >= P gives constant high (100%).
- Output level:
  - pwm_out[i] = raw_i ^ pol_i.
  - When enable=0, pwm_out[i] = pol_i, i.e. the inactive level.
- Reset mid-period: everything returns to reset values immediately. Shadow contents are lost, and pending commits are dropped.

## Timing
- pwm_out and period_start are registered and lag cnt by one clock.
- Within each full period, pwm_out[i] is high (pol_i=0) for exactly min(duty_i, P) consecutive cycles, modulo P, starting ph_i cycles after period_start.
- Latency from enable rising (with P >= 1) to the first period_start is 1 cycle.
- period_start is asserted for one cycle each time cnt = 0 is presented to the output register with enable=1 and P >= 1.
- New settings appear on pwm_out in the cycle after the commit edge, at the same time as period_start.
- A commit never truncates or extends a running period, except that while idle it applies on the next edge.

## Configuration
- PWM_PHASE_EN:
  - Defined: the per-channel phase registers and the position subtract/wrap logic are built as described.
  - Undefined: phase writes (cfg_sel=1) are ignored, ph_i is treated as 0 for every channel (pos_i = cnt), and the phase registers and adders are not synthesised. All other behaviour is identical.

## Test plan
- Reset/idle: drive rst=0 mid-run, then release with enable=0 and pol=0 -> pwm_out=0, period_start=0, commit_pending=0.
- Basic duty:
  - Stimulus: P=10; duty ch0=3, ch1=0, ch2=10, ch3=15; commit; enable.
  - Required: ch0 high for 3 of every 10 cycles starting at period_start; ch1 constant 0; ch2 and ch3 constant 1; period_start every 10 cycles.
- Phase (PWM_PHASE_EN):
  - Stimulus: P=8, duty ch1=4, phase ch1=6.
  - Required: ch1 high on cycles 6,7,0,1 of each period.
  - Stimulus: phase=9. Required: behaves as phase 0.
- Glitch-free commit:
  - Stimulus: while running P=10/duty=3, write duty=7 and P=20, then pulse cfg_commit at cnt=4.
  - Required: commit_pending=1 until the edge at cnt=9; the current period completes unchanged; the next period is 20 cycles long with 7 high.
- Boundary collisions:
  - cfg_commit exactly at cnt=P-1 -> applies at that edge.
  - A cfg_we on the same edge -> not in the active set; appears only after the next commit.
- Polarity/enable:
  - Stimulus: pol ch0=1, duty=3, P=10.
  - Required: ch0 low for 3 cycles, high for 7.
  - Stimulus: enable=0. Required: ch0=1, cnt held at 0; a commit applies on the next edge.

Source files
------------

// File: rtl/pwm_multi_driver_if.sv
// pwm_multi_driver_if: configuration port of the multi-channel PWM driver.
// Carries shadow-register writes, the commit request and the pending flag.
interface pwm_multi_driver_if #(
  parameter int PWM_SIZE = 32,
  parameter int CH_W     = 2
);
  logic                cfg_we;
  logic [1:0]          cfg_sel;
  logic [CH_W-1:0]     cfg_ch;
  logic [PWM_SIZE-1:0] cfg_data;
  logic                cfg_commit;
  logic                commit_pending;

  modport master (
    output cfg_we, cfg_sel, cfg_ch, cfg_data, cfg_commit,
    input  commit_pending
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_ch, cfg_data, cfg_commit,
    output commit_pending
  );
endinterface

// File: rtl/pwm_multi_driver.sv
// pwm_multi_driver: NUM_CH PWM outputs on one shared period counter.
// Shadowed config commits at period boundaries; PWM_PHASE_EN adds phases.
module pwm_multi_driver #(
  parameter int PWM_SIZE = 32,
  parameter int NUM_CH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  pwm_multi_driver_if.slave cfg,
  output logic              period_start,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef logic [PWM_SIZE-1:0] word_t;

  word_t             sh_duty [NUM_CH];
  word_t             act_duty[NUM_CH];
  word_t             sh_period;
  word_t             act_period;
  logic [NUM_CH-1:0] sh_pol;
  logic [NUM_CH-1:0] act_pol;
`ifdef PWM_PHASE_EN
  word_t             sh_phase [NUM_CH];
  word_t             act_phase[NUM_CH];
  logic [PWM_SIZE:0] ph;
`endif

  word_t             cnt;
  logic              pending;
  logic              idle;
  logic              last;
  logic              boundary;
  logic              do_commit;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] raw;
  logic [PWM_SIZE:0] pos;

  assign idle      = !enable || (act_period == '0);
  assign last      = (cnt == act_period - PWM_SIZE'(1));
  assign boundary  = idle || last;
  assign do_commit = boundary && (pending || cfg.cfg_commit);

  assign cfg.commit_pending = pending;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i] = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_period <= '0;
      sh_pol    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        sh_duty[i] <= '0;
`ifdef PWM_PHASE_EN
        sh_phase[i] <= '0;
`endif
      end
    end else begin
      if (cfg.cfg_we && (cfg.cfg_sel == 2'd2)) begin
        sh_period <= cfg.cfg_data;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (hit[i]) begin
          unique case (cfg.cfg_sel)
            2'd0: sh_duty[i] <= cfg.cfg_data;
`ifdef PWM_PHASE_EN
            2'd1: sh_phase[i] <= cfg.cfg_data;
`endif
            2'd3: sh_pol[i] <= cfg.cfg_data[0];
            default: ;
          endcase
        end
      end
    end
  end

  // Active set only moves at a boundary, so a period never mixes settings.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_period <= '0;
      act_pol    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        act_duty[i] <= '0;
`ifdef PWM_PHASE_EN
        act_phase[i] <= '0;
`endif
      end
    end else if (do_commit) begin
      act_period <= sh_period;
      act_pol    <= sh_pol;
      for (int i = 0; i < NUM_CH; i++) begin
        act_duty[i] <= sh_duty[i];
`ifdef PWM_PHASE_EN
        act_phase[i] <= sh_phase[i];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      cnt <= boundary ? '0 : cnt + PWM_SIZE'(1);
      if (do_commit) begin
        pending <= 1'b0;
      end else if (cfg.cfg_commit) begin
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    raw = '0;
    pos = '0;
`ifdef PWM_PHASE_EN
    ph  = '0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      pos = {1'b0, cnt};
`ifdef PWM_PHASE_EN
      ph = '0;
      if (act_phase[i] < act_period) begin
        ph = {1'b0, act_phase[i]};
      end
      if ({1'b0, cnt} >= ph) begin
        pos = {1'b0, cnt} - ph;
      end else begin
        pos = {1'b0, cnt} + {1'b0, act_period} - ph;
      end
`endif
      raw[i] = (act_period != '0) && (pos < {1'b0, act_duty[i]});
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_start <= 1'b0;
      pwm_out      <= '0;
    end else begin
      period_start <= enable && (act_period != '0) && (cnt == '0);
      pwm_out      <= enable ? (raw ^ act_pol) : act_pol;
    end
  end

endmodule

// File: tb/tb_pwm_multi_driver.sv
// tb_pwm_multi_driver: directed stimulus, spec-level model compared every
// cycle, plus literal pattern checks that pin the model.
module tb_pwm_multi_driver;

  localparam int PW = 32;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          period_start;
  logic [NC-1:0] pwm_out;
  logic          chk_on = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  pwm_multi_driver_if #(.PWM_SIZE(PW), .CH_W(2)) bus ();

  pwm_multi_driver #(.PWM_SIZE(PW), .NUM_CH(NC)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .cfg          (bus),
    .period_start (period_start),
    .pwm_out      (pwm_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  longint        m_duty[NC];
  longint        s_duty[NC];
`ifdef PWM_PHASE_EN
  longint        m_phase[NC];
  longint        s_phase[NC];
`endif
  logic [NC-1:0] m_pol, s_pol;
  longint        m_per, s_per, t;
  logic          m_pend;
  logic [NC-1:0] e_out;
  logic          e_ps;
  longint        ph, d;
  logic          hi, m_idle, m_bnd;

  // Spec-level model: output high while (t - phase) mod P < min(duty, P).
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NC; i++) begin
        m_duty[i] = 0;
        s_duty[i] = 0;
`ifdef PWM_PHASE_EN
        m_phase[i] = 0;
        s_phase[i] = 0;
`endif
      end
      m_pol = '0; s_pol = '0; m_per = 0; s_per = 0; t = 0;
      m_pend = 1'b0; e_out = '0; e_ps = 1'b0;
    end else begin
      e_ps = enable && (m_per != 0) && (t == 0);
      for (int i = 0; i < NC; i++) begin
        hi = 1'b0;
        if (m_per != 0) begin
          ph = 0;
`ifdef PWM_PHASE_EN
          if (m_phase[i] < m_per) ph = m_phase[i];
`endif
          d  = (m_duty[i] < m_per) ? m_duty[i] : m_per;
          hi = (((t - ph + m_per) % m_per) < d);
        end
        e_out[i] = enable ? (hi ^ m_pol[i]) : m_pol[i];
      end
      m_idle = !enable || (m_per == 0);
      m_bnd  = m_idle || (t == m_per - 1);
      if (m_bnd && (m_pend || bus.cfg_commit)) begin
        m_duty = s_duty;
`ifdef PWM_PHASE_EN
        m_phase = s_phase;
`endif
        m_pol = s_pol; m_per = s_per; t = 0; m_pend = 1'b0;
      end else begin
        if (bus.cfg_commit) m_pend = 1'b1;
        t = m_idle ? 0 : ((t == m_per - 1) ? 0 : t + 1);
      end
      if (bus.cfg_we) begin
        case (bus.cfg_sel)
          2'd0: s_duty[bus.cfg_ch] = {32'b0, bus.cfg_data};
`ifdef PWM_PHASE_EN
          2'd1: s_phase[bus.cfg_ch] = {32'b0, bus.cfg_data};
`endif
          2'd2: s_per = {32'b0, bus.cfg_data};
          2'd3: s_pol[bus.cfg_ch] = bus.cfg_data[0];
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model pwm_out", 64'(pwm_out), 64'(e_out));
      check("model period_start", 64'(period_start), 64'(e_ps));
      check("model commit_pending", 64'(bus.commit_pending), 64'(m_pend));
    end
  end

  logic [NC-1:0] h_out[64];
  logic          h_ps[64];

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [1:0] ch,
                    input logic [31:0] dat);
    bus.cfg_we = 1'b1; bus.cfg_sel = sel; bus.cfg_ch = ch; bus.cfg_data = dat;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic commit();
    bus.cfg_commit = 1'b1;
    @(negedge clk);
    bus.cfg_commit = 1'b0;
  endtask

  task automatic wait_ps(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 100);
    if (!period_start) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_ps: no period_start within %0d cycles", n);
    end
  endtask

  task automatic grab(input int n);
    for (int k = 0; k < n; k++) begin
      h_out[k] = pwm_out;
      h_ps[k]  = period_start;
      @(negedge clk);
    end
  endtask

  function automatic logic [63:0] pat(input int ch, input int n);
    logic [63:0] r = '0;
    for (int k = 0; k < n; k++) r[k] = h_out[k][ch];
    return r;
  endfunction

  function automatic logic [63:0] psp(input int n);
    logic [63:0] r = '0;
    for (int k = 0; k < n; k++) r[k] = h_ps[k];
    return r;
  endfunction

  int n;

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_sel = '0; bus.cfg_ch = '0;
    bus.cfg_data = '0; bus.cfg_commit = 1'b0;
    #1 rst = 1'b0;
    cyc(3);
    rst = 1'b1;
    chk_on = 1'b1;
    cyc(2);
    check("reset pwm_out", 64'(pwm_out), 64'h0);
    check("reset period_start", 64'(period_start), 64'h0);
    check("reset commit_pending", 64'(bus.commit_pending), 64'h0);

    wr(2'd2, 2'd0, 32'd10);
    wr(2'd0, 2'd0, 32'd3);
    wr(2'd0, 2'd1, 32'd0);
    wr(2'd0, 2'd2, 32'd10);
    wr(2'd0, 2'd3, 32'd15);
    commit();
    enable = 1'b1;
    wait_ps(n);
    grab(20);
    check("basic ch0", pat(0, 20), 64'h01C07);
    check("basic ch1", pat(1, 20), 64'h0);
    check("basic ch2", pat(2, 20), 64'hFFFFF);
    check("basic ch3", pat(3, 20), 64'hFFFFF);
    check("basic period_start", psp(20), 64'h00401);

    wr(2'd0, 2'd0, 32'd7);
    wr(2'd2, 2'd0, 32'd20);
    cyc(1);
    commit();
    check("glitch pending", 64'(bus.commit_pending), 64'h1);
    wait_ps(n);
    check("glitch period len", 64'(n), 64'd6);
    check("glitch pending clr", 64'(bus.commit_pending), 64'h0);
    grab(20);
    check("glitch ch0", pat(0, 20), 64'h0007F);
    check("glitch period_start", psp(20), 64'h1);

    wr(2'd0, 2'd1, 32'd4);
    cyc(17);
    bus.cfg_commit = 1'b1;
    bus.cfg_we = 1'b1; bus.cfg_sel = 2'd0; bus.cfg_ch = 2'd0;
    bus.cfg_data = 32'd5;
    @(negedge clk);
    bus.cfg_commit = 1'b0;
    bus.cfg_we = 1'b0;
    check("collide pending", 64'(bus.commit_pending), 64'h0);
    wait_ps(n);
    grab(20);
    check("collide ch1", pat(1, 20), 64'h0000F);
    check("collide ch0 old", pat(0, 20), 64'h0007F);
    commit();
    wait_ps(n);
    grab(20);
    check("collide ch0 new", pat(0, 20), 64'h0001F);

    wr(2'd2, 2'd0, 32'd8);
    wr(2'd0, 2'd1, 32'd4);
    wr(2'd1, 2'd1, 32'd6);
    commit();
    wait_ps(n);
    grab(8);
`ifdef PWM_PHASE_EN
    check("phase6 ch1", pat(1, 8), 64'hC3);
`else
    check("phase6 ch1", pat(1, 8), 64'h0F);
`endif
    check("phase6 ch0", pat(0, 8), 64'h1F);
    wr(2'd1, 2'd1, 32'd9);
    commit();
    wait_ps(n);
    grab(8);
    check("phase9 ch1", pat(1, 8), 64'h0F);

    wr(2'd2, 2'd0, 32'd10);
    wr(2'd0, 2'd0, 32'd3);
    wr(2'd3, 2'd0, 32'd1);
    commit();
    wait_ps(n);
    grab(10);
    check("pol ch0", pat(0, 10), 64'h3F8);

    enable = 1'b0;
    cyc(2);
    check("idle ch0", 64'(pwm_out[0]), 64'h1);
    check("idle period_start", 64'(period_start), 64'h0);
    wr(2'd0, 2'd0, 32'd2);
    commit();
    check("idle commit", 64'(bus.commit_pending), 64'h0);
    enable = 1'b1;
    wait_ps(n);
    check("enable latency", 64'(n), 64'd1);
    grab(10);
    check("idle applied ch0", pat(0, 10), 64'h3FC);

    commit();
    check("pre-reset pending", 64'(bus.commit_pending), 64'h1);
    #2 rst = 1'b0;
    #1;
    check("async pwm_out", 64'(pwm_out), 64'h0);
    check("async period_start", 64'(period_start), 64'h0);
    check("async pending", 64'(bus.commit_pending), 64'h0);
    @(negedge clk);
    enable = 1'b0;
    rst = 1'b1;
    cyc(3);
    check("post-reset pwm_out", 64'(pwm_out), 64'h0);
    check("post-reset pending", 64'(bus.commit_pending), 64'h0);
    enable = 1'b1;
    cyc(3);
    check("post-reset P0", 64'(pwm_out), 64'h0);
    check("post-reset ps", 64'(period_start), 64'h0);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
